gcd_job_issuer: RTL and testbench

Initiator-side sequencer for the team's subtractive GCD core, which has a start/done handshake, a shared operand bus and a sticky DONE state. It accepts operand pairs on a valid/ready input stream and drives the core's start and data bus through the LOADA/LOADB cycles. It waits for done with a timeout guard, returns the result on a valid/ready output stream, then clears the core back to IDLE for the next job. Zero operands are handled locally because the subtractive core never terminates on them.

---
 rtl/gcd_job_issuer_if.sv | 29 ++
 rtl/gcd_job_issuer.sv | 114 +++++++++++
 tb/tb_gcd_job_issuer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_job_issuer_if.sv
// Operand stream, result stream and GCD core bus seen by the job issuer.
// The issuer uses the slave modport; the stream source/sink and core use master.
interface gcd_job_issuer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic             core_start;
  logic             core_clear;
  logic [WIDTH-1:0] core_data;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  modport master (
    output in_valid, in_a, in_b, out_ready, core_done, core_result,
    input  in_ready, out_valid, out_gcd, out_err, core_start, core_clear, core_data
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready, core_done, core_result,
    output in_ready, out_valid, out_gcd, out_err, core_start, core_clear, core_data
  );
endinterface

// File: rtl/gcd_job_issuer.sv
// Sequences one GCD job at a time through a start/done subtractive core,
// resolving zero operands locally and aborting jobs that never finish.
module gcd_job_issuer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  gcd_job_issuer_if.slave  bus,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    FEED_A = 3'd2,
    FEED_B = 3'd3,
    WAIT   = 3'd4,
    CLEAR  = 3'd5
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] out_gcd_reg;
  logic             out_err_reg;
  logic             out_valid_reg;
  logic [CW-1:0]    count_reg;

  logic accept;
  logic drain;
  logic zero_op;

  // Accept only when the output slot is free or drains on this same edge.
  assign drain   = out_valid_reg && bus.out_ready;
  assign accept  = bus.in_valid && bus.in_ready;
  assign zero_op = (bus.in_a == '0) || (bus.in_b == '0);

  assign bus.in_ready  = (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_gcd   = out_gcd_reg;
  assign bus.out_err   = out_err_reg;
  assign busy          = (state_reg != IDLE);

  // Core controls decode from state only, so upstream/downstream inputs never reach them.
  assign bus.core_start = (state_reg == START);
  assign bus.core_clear = !reset_n || (state_reg == CLEAR);

  always_comb begin
    bus.core_data = '0;
    case (state_reg)
      START, FEED_A: bus.core_data = op_a_reg;
      FEED_B:        bus.core_data = op_b_reg;
      default:       bus.core_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      out_gcd_reg   <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      if (drain) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg <= bus.in_a;
            op_b_reg <= bus.in_b;
            if (zero_op) begin
              // The core never terminates on a zero operand; answer directly.
              out_gcd_reg   <= bus.in_a | bus.in_b;
              out_err_reg   <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= START;
            end
          end
        end
        START:  state_reg <= FEED_A;
        FEED_A: state_reg <= FEED_B;
        FEED_B: begin
          count_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          count_reg <= count_reg + 1'b1;
          if (bus.core_done) begin
            out_gcd_reg   <= bus.core_result;
            out_err_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= CLEAR;
          end else if (count_reg == CW'(TIMEOUT - 1)) begin
            out_gcd_reg   <= '0;
            out_err_reg   <= 1'b1;
            out_valid_reg <= 1'b1;
            state_reg     <= CLEAR;
          end
        end
        CLEAR:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_issuer.sv
// Directed bench for gcd_job_issuer with a small Euclid core model that can be
// told to hang, so the timeout path and mid-job reset can be exercised.
module tb_gcd_job_issuer;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  always #5 clk = ~clk;

  gcd_job_issuer_if #(.WIDTH(8)) bus ();

  gcd_job_issuer #(.WIDTH(8), .TIMEOUT(20), .CW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy    (busy)
  );

  // Core model: LOADA after start, LOADB next, then one Euclid step per cycle.
  typedef enum logic [1:0] {M_IDLE, M_LA, M_LB, M_RUN} mstate_t;
  mstate_t    m_st;
  logic [7:0] m_a, m_b;
  logic       m_done;
  logic       hang;

  assign bus.core_done   = m_done;
  assign bus.core_result = m_a;

  always @(posedge clk) begin
    if (bus.core_clear) begin
      m_st <= M_IDLE; m_a <= 8'd0; m_b <= 8'd0; m_done <= 1'b0;
    end else begin
      case (m_st)
        M_IDLE: if (bus.core_start) m_st <= M_LA;
        M_LA:   begin m_a <= bus.core_data; m_st <= M_LB; end
        M_LB:   begin m_b <= bus.core_data; m_st <= M_RUN; end
        M_RUN:  if (!hang) begin
                  if (m_b == 8'd0) m_done <= 1'b1;
                  else begin m_a <= m_b; m_b <= m_a % m_b; end
                end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Event monitor, sampled mid-cycle where every signal has settled.
  int         start_cnt = 0;
  int         clear_cnt = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.core_start) start_cnt++;
      if (bus.core_clear) clear_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_gcd);
        $display("result gcd=%0d err=%0d t=%0t", bus.out_gcd, bus.out_err, $time);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) break;
      tick();
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    $display("send a=%0d b=%0d t=%0t", a, b, $time);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) break;
      tick();
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  int s0, c0, q0;

  initial begin
    hang          = 1'b0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_gcd",    32'(bus.out_gcd),    32'd0);
    check("rst_out_err",    32'(bus.out_err),    32'd0);
    check("rst_core_start", 32'(bus.core_start), 32'd0);
    check("rst_core_data",  32'(bus.core_data),  32'd0);
    check("rst_core_clear", 32'(bus.core_clear), 32'd1);
    check("rst_busy",       32'(busy),           32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("idle_clear", 32'(bus.core_clear), 32'd0);

    // (48,18) through the core
    s0 = start_cnt; c0 = clear_cnt;
    send(8'd48, 8'd18);
    check("t1_start",    32'(bus.core_start), 32'd1);
    check("t1_data_st",  32'(bus.core_data),  32'd48);
    check("t1_busy",     32'(busy),           32'd1);
    tick();
    check("t1_start_fa", 32'(bus.core_start), 32'd0);
    check("t1_data_fa",  32'(bus.core_data),  32'd48);
    tick();
    check("t1_data_fb",  32'(bus.core_data),  32'd18);
    tick();
    check("t1_data_wt",  32'(bus.core_data),  32'd0);
    wait_valid("t1_valid");
    check("t1_gcd",      32'(bus.out_gcd),    32'd6);
    check("t1_err",      32'(bus.out_err),    32'd0);
    check("t1_clear",    32'(bus.core_clear), 32'd1);
    pop();
    tick();
    check("t1_nstart",   32'(start_cnt - s0), 32'd1);
    check("t1_nclear",   32'(clear_cnt - c0), 32'd1);

    // zero bypass
    s0 = start_cnt;
    send(8'd0, 8'd35);
    check("t2_valid",  32'(bus.out_valid), 32'd1);
    check("t2_gcd",    32'(bus.out_gcd),   32'd35);
    check("t2_err",    32'(bus.out_err),   32'd0);
    check("t2_busy",   32'(busy),          32'd0);
    pop();
    send(8'd0, 8'd0);
    check("t2z_valid", 32'(bus.out_valid), 32'd1);
    check("t2z_gcd",   32'(bus.out_gcd),   32'd0);
    check("t2z_err",   32'(bus.out_err),   32'd0);
    pop();
    check("t2_nstart", 32'(start_cnt - s0), 32'd0);

    // timeout: 20 WAIT cycles after FEED_B
    hang = 1'b1;
    send(8'd5, 8'd3);
    tick(); tick(); tick();
    check("t3_first_wait", 32'(busy), 32'd1);
    for (int i = 0; i < 19; i++) tick();
    check("t3_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    check("t3_valid", 32'(bus.out_valid),  32'd1);
    check("t3_err",   32'(bus.out_err),    32'd1);
    check("t3_gcd",   32'(bus.out_gcd),    32'd0);
    check("t3_clear", 32'(bus.core_clear), 32'd1);
    pop();
    hang = 1'b0;

    // backpressure
    send(8'd255, 8'd1);
    wait_valid("t4_valid");
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_gcd", 32'(bus.out_gcd),  32'd1);
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    check("t4_drained", 32'(bus.out_valid), 32'd0);

    // back-to-back
    q0 = got_q.size();
    bus.out_ready = 1'b1;
    send(8'd12, 8'd8);
    send(8'd7, 8'd7);
    send(8'd9, 8'd0);
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() >= q0 + 3) break;
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    bus.out_ready = 1'b0;
    check("t5_count", 32'(got_q.size() - q0), 32'd3);
    if (got_q.size() >= q0 + 3) begin
      check("t5_r0", 32'(got_q[q0]),     32'd4);
      check("t5_r1", 32'(got_q[q0 + 1]), 32'd7);
      check("t5_r2", 32'(got_q[q0 + 2]), 32'd9);
    end

    // reset mid-job
    hang = 1'b1;
    send(8'd100, 8'd75);
    for (int i = 0; i < 5; i++) tick();
    check("t6_in_wait", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.out_valid),  32'd0);
    check("t6_gcd",   32'(bus.out_gcd),    32'd0);
    check("t6_err",   32'(bus.out_err),    32'd0);
    check("t6_start", 32'(bus.core_start), 32'd0);
    check("t6_data",  32'(bus.core_data),  32'd0);
    check("t6_clear", 32'(bus.core_clear), 32'd1);
    check("t6_busy",  32'(busy),           32'd0);
    tick(); tick();
    hang = 1'b0;
    reset_n = 1'b1;
    tick();
    send(8'd21, 8'd14);
    wait_valid("t6b_valid");
    check("t6b_gcd", 32'(bus.out_gcd), 32'd7);
    check("t6b_err", 32'(bus.out_err), 32'd0);
    pop();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
